spi_frame_loader: RTL and testbench

Receives the host's SPI load stream, deserialises it into bytes in the system clock domain, decodes a per-frame header, and writes packed words into the instruction, parameter or activation memory. It sits between the SPI pins and the three on-chip memories inside the top-level design. All memory contents are loaded through it before the processor is released to run.

---
 rtl/spi_frame_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_spi_frame_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_loader.sv
// spi_frame_loader: SPI load-stream receiver. Synchronises the SPI pins into
// clk, assembles bytes, decodes the frame header and start address, and
// packs data bytes into instruction, parameter or activation memory writes.
module spi_frame_loader #(
   parameter int unsigned WIDTH_SPI_WORD   = 8,
   parameter int unsigned WIDTH_INST_MEM   = 80,
   parameter int unsigned WIDTH_ADDR_INST  = 6,
   parameter int unsigned DEPTH_INST_MEM   = 64,
   parameter int unsigned WIDTH_PARAM_MEM  = 128,
   parameter int unsigned WIDTH_ADDR_PARAM = 13,
   parameter int unsigned DEPTH_PARAM_MEM  = 7000,
   parameter int unsigned WIDTH_ACT_MEM    = 8,
   parameter int unsigned WIDTH_ADDR_ACT   = 12,
   parameter int unsigned DEPTH_ACT_MEM    = 4096,
   parameter logic [1:0]  INST_MEM_HEADER  = 2'b11,
   parameter logic [1:0]  PARAM_MEM_HEADER = 2'b01,
   parameter logic [1:0]  ACT_MEM_HEADER   = 2'b10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        spi_clk,
   input  logic                        MOSI,
   input  logic                        chip_select_n,
   output logic                        inst_we,
   output logic [WIDTH_ADDR_INST-1:0]  inst_addr,
   output logic [WIDTH_INST_MEM-1:0]   inst_wdata,
   output logic                        param_we,
   output logic [WIDTH_ADDR_PARAM-1:0] param_addr,
   output logic [WIDTH_PARAM_MEM-1:0]  param_wdata,
   output logic                        act_we,
   output logic [WIDTH_ADDR_ACT-1:0]   act_addr,
   output logic [WIDTH_ACT_MEM-1:0]    act_wdata,
   output logic                        frame_active,
   output logic                        frame_done,
   output logic                        header_err
);

   localparam int unsigned BW  = WIDTH_SPI_WORD;
   localparam int unsigned BCW = $clog2(BW);
   // Start address arrives as two bytes.
   localparam int unsigned AW  = 2 * BW;

   localparam int unsigned INST_BYTES  = WIDTH_INST_MEM / BW;
   localparam int unsigned PARAM_BYTES = WIDTH_PARAM_MEM / BW;
   localparam int unsigned ACT_BYTES   = WIDTH_ACT_MEM / BW;

   localparam int unsigned MAX_W0 = (WIDTH_INST_MEM > WIDTH_PARAM_MEM) ? WIDTH_INST_MEM : WIDTH_PARAM_MEM;
   localparam int unsigned MAX_W1 = (MAX_W0 > WIDTH_ACT_MEM) ? MAX_W0 : WIDTH_ACT_MEM;
   localparam int unsigned PACK_W = (MAX_W1 > 2 * BW) ? MAX_W1 : 2 * BW;

   localparam logic [AW-1:0] INST_MASK  = AW'((32'd1 << WIDTH_ADDR_INST) - 32'd1);
   localparam logic [AW-1:0] PARAM_MASK = AW'((32'd1 << WIDTH_ADDR_PARAM) - 32'd1);
   localparam logic [AW-1:0] ACT_MASK   = AW'((32'd1 << WIDTH_ADDR_ACT) - 32'd1);
   localparam logic [AW-1:0] INST_LAST  = AW'(DEPTH_INST_MEM - 1);
   localparam logic [AW-1:0] PARAM_LAST = AW'(DEPTH_PARAM_MEM - 1);
   localparam logic [AW-1:0] ACT_LAST   = AW'(DEPTH_ACT_MEM - 1);
   localparam logic [7:0]    INST_CNT_LAST  = 8'(INST_BYTES - 1);
   localparam logic [7:0]    PARAM_CNT_LAST = 8'(PARAM_BYTES - 1);
   localparam logic [7:0]    ACT_CNT_LAST   = 8'(ACT_BYTES - 1);

   typedef enum logic [2:0] {IDLE, HEADER, ADDR_HI, ADDR_LO, DATA, DISCARD} state_t;
   typedef enum logic [1:0] {T_INST, T_PARAM, T_ACT} target_t;

   // ---------------------------------------------------------------------
   // Synchronisers: bit 0 is the first stage, bit 1 the synchronised value,
   // bit 2 the previous synchronised value for edge detection.
   // ---------------------------------------------------------------------
   logic [2:0] sclk_sync_q, sclk_sync_d;
   logic [1:0] mosi_sync_q, mosi_sync_d;
   logic [2:0] csn_sync_q,  csn_sync_d;

   // Shift the asynchronous pins into the synchroniser chains.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
      mosi_sync_d = {mosi_sync_q[0], MOSI};
      csn_sync_d  = {csn_sync_q[1:0], chip_select_n};
   end

   // Synchroniser registers. The chip-select chain resets low so that a
   // frame can only start after chip_select_n is seen high, then low.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         csn_sync_q  <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         csn_sync_q  <= csn_sync_d;
      end
   end

   logic sclk_rise, mosi_bit, csn_hi, csn_rise, csn_fall;
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign mosi_bit  = mosi_sync_q[1];
   assign csn_hi    = csn_sync_q[1];
   assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
   assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];

   // ---------------------------------------------------------------------
   // Byte assembly
   // ---------------------------------------------------------------------
   logic [BW-1:0]  shift_q, shift_d, shift_nx;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic           byte_vld_q, byte_vld_d;
   logic [BW-1:0]  byte_q, byte_d;

   // Shift MOSI in MSB-first on each synchronised spi_clk rising edge;
   // hold the counter and shifter clear while chip select is high.
   always_comb begin
      shift_nx   = {shift_q[BW-2:0], mosi_bit};
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      byte_vld_d = 1'b0;
      byte_d     = byte_q;
      if (csn_hi) begin
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (sclk_rise) begin
         shift_d   = shift_nx;
         bit_cnt_d = bit_cnt_q + BCW'(1);
         if (bit_cnt_q == BCW'(BW - 1)) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_nx;
         end
      end
   end

   // Byte assembly registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_vld_q <= 1'b0;
         byte_q     <= '0;
      end else begin
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_vld_q <= byte_vld_d;
         byte_q     <= byte_d;
      end
   end

   // ---------------------------------------------------------------------
   // Frame FSM, word packer and output registers
   // ---------------------------------------------------------------------
   state_t             state_q, state_d;
   target_t            target_q, target_d;
   logic [BW-1:0]      addr_hi_q, addr_hi_d;
   logic [AW-1:0]      cur_addr_q, cur_addr_d;
   logic [PACK_W-BW-1:0] pack_q, pack_d;
   logic [7:0]         byte_cnt_q, byte_cnt_d;
   logic               frame_done_q, frame_done_d;
   logic               header_err_q, header_err_d;

   logic                        inst_we_q, inst_we_d;
   logic [WIDTH_ADDR_INST-1:0]  inst_addr_q, inst_addr_d;
   logic [WIDTH_INST_MEM-1:0]   inst_wdata_q, inst_wdata_d;
   logic                        param_we_q, param_we_d;
   logic [WIDTH_ADDR_PARAM-1:0] param_addr_q, param_addr_d;
   logic [WIDTH_PARAM_MEM-1:0]  param_wdata_q, param_wdata_d;
   logic                        act_we_q, act_we_d;
   logic [WIDTH_ADDR_ACT-1:0]   act_addr_q, act_addr_d;
   logic [WIDTH_ACT_MEM-1:0]    act_wdata_q, act_wdata_d;

   logic [PACK_W-1:0] pack_shift;
   logic [7:0]        cnt_last;
   logic [AW-1:0]     addr_mask, addr_last, addr_next;
   logic [1:0]        hdr_code;

   assign pack_shift = {pack_q, byte_q};
   assign hdr_code   = byte_q[BW-1:BW-2];

   // Per-target word size, address mask and wrap point.
   always_comb begin
      cnt_last  = INST_CNT_LAST;
      addr_mask = INST_MASK;
      addr_last = INST_LAST;
      unique case (target_q)
         T_PARAM: begin
            cnt_last  = PARAM_CNT_LAST;
            addr_mask = PARAM_MASK;
            addr_last = PARAM_LAST;
         end
         T_ACT: begin
            cnt_last  = ACT_CNT_LAST;
            addr_mask = ACT_MASK;
            addr_last = ACT_LAST;
         end
         default: ;
      endcase
      addr_next = (cur_addr_q == addr_last) ? '0 : ((cur_addr_q + AW'(1)) & addr_mask);
   end

   // Next-state, packing and write-strobe logic. A write produced by the
   // final byte is kept even when chip-select deassertion is seen in the
   // same cycle; the frame-end override only touches state and the packer.
   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      addr_hi_d     = addr_hi_q;
      cur_addr_d    = cur_addr_q;
      pack_d        = pack_q;
      byte_cnt_d    = byte_cnt_q;
      frame_done_d  = 1'b0;
      header_err_d  = header_err_q;
      inst_we_d     = 1'b0;
      inst_addr_d   = inst_addr_q;
      inst_wdata_d  = inst_wdata_q;
      param_we_d    = 1'b0;
      param_addr_d  = param_addr_q;
      param_wdata_d = param_wdata_q;
      act_we_d      = 1'b0;
      act_addr_d    = act_addr_q;
      act_wdata_d   = act_wdata_q;

      unique case (state_q)
         IDLE: begin
            pack_d     = '0;
            byte_cnt_d = '0;
            if (csn_fall) state_d = HEADER;
         end
         HEADER: begin
            if (byte_vld_q) begin
               state_d = ADDR_HI;
               if (hdr_code == INST_MEM_HEADER) begin
                  target_d = T_INST;
               end else if (hdr_code == PARAM_MEM_HEADER) begin
                  target_d = T_PARAM;
               end else if (hdr_code == ACT_MEM_HEADER) begin
                  target_d = T_ACT;
               end else begin
                  state_d      = DISCARD;
                  header_err_d = 1'b1;
               end
            end
         end
         ADDR_HI: begin
            if (byte_vld_q) begin
               addr_hi_d = byte_q;
               state_d   = ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (byte_vld_q) begin
               cur_addr_d = {addr_hi_q, byte_q} & addr_mask;
               pack_d     = '0;
               byte_cnt_d = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (byte_vld_q) begin
               if (byte_cnt_q == cnt_last) begin
                  pack_d     = '0;
                  byte_cnt_d = '0;
                  cur_addr_d = addr_next;
                  unique case (target_q)
                     T_PARAM: begin
                        param_we_d    = 1'b1;
                        param_addr_d  = cur_addr_q[WIDTH_ADDR_PARAM-1:0];
                        param_wdata_d = pack_shift[WIDTH_PARAM_MEM-1:0];
                     end
                     T_ACT: begin
                        act_we_d    = 1'b1;
                        act_addr_d  = cur_addr_q[WIDTH_ADDR_ACT-1:0];
                        act_wdata_d = pack_shift[WIDTH_ACT_MEM-1:0];
                     end
                     default: begin
                        inst_we_d    = 1'b1;
                        inst_addr_d  = cur_addr_q[WIDTH_ADDR_INST-1:0];
                        inst_wdata_d = pack_shift[WIDTH_INST_MEM-1:0];
                     end
                  endcase
               end else begin
                  pack_d     = pack_shift[PACK_W-BW-1:0];
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
            end
         end
         DISCARD: ;
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && csn_rise) begin
         state_d      = IDLE;
         frame_done_d = 1'b1;
         pack_d       = '0;
         byte_cnt_d   = '0;
      end
   end

   // Frame state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         target_q      <= T_INST;
         addr_hi_q     <= '0;
         cur_addr_q    <= '0;
         pack_q        <= '0;
         byte_cnt_q    <= '0;
         frame_done_q  <= 1'b0;
         header_err_q  <= 1'b0;
         inst_we_q     <= 1'b0;
         inst_addr_q   <= '0;
         inst_wdata_q  <= '0;
         param_we_q    <= 1'b0;
         param_addr_q  <= '0;
         param_wdata_q <= '0;
         act_we_q      <= 1'b0;
         act_addr_q    <= '0;
         act_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         addr_hi_q     <= addr_hi_d;
         cur_addr_q    <= cur_addr_d;
         pack_q        <= pack_d;
         byte_cnt_q    <= byte_cnt_d;
         frame_done_q  <= frame_done_d;
         header_err_q  <= header_err_d;
         inst_we_q     <= inst_we_d;
         inst_addr_q   <= inst_addr_d;
         inst_wdata_q  <= inst_wdata_d;
         param_we_q    <= param_we_d;
         param_addr_q  <= param_addr_d;
         param_wdata_q <= param_wdata_d;
         act_we_q      <= act_we_d;
         act_addr_q    <= act_addr_d;
         act_wdata_q   <= act_wdata_d;
      end
   end

   assign inst_we      = inst_we_q;
   assign inst_addr    = inst_addr_q;
   assign inst_wdata   = inst_wdata_q;
   assign param_we     = param_we_q;
   assign param_addr   = param_addr_q;
   assign param_wdata  = param_wdata_q;
   assign act_we       = act_we_q;
   assign act_addr     = act_addr_q;
   assign act_wdata    = act_wdata_q;
   assign frame_active = (state_q != IDLE);
   assign frame_done   = frame_done_q;
   assign header_err   = header_err_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed testbench for spi_frame_loader: drives SPI frames bit by bit and
// checks every memory write, frame_done, header_err and the reset behaviour.
module tb_spi_frame_loader;

   logic         clk = 1'b0;
   logic         reset;
   logic         spi_clk;
   logic         MOSI;
   logic         chip_select_n;
   logic         inst_we;
   logic [5:0]   inst_addr;
   logic [79:0]  inst_wdata;
   logic         param_we;
   logic [12:0]  param_addr;
   logic [127:0] param_wdata;
   logic         act_we;
   logic [11:0]  act_addr;
   logic [7:0]   act_wdata;
   logic         frame_active;
   logic         frame_done;
   logic         header_err;

   spi_frame_loader #(
      .WIDTH_SPI_WORD(8),
      .WIDTH_INST_MEM(80),
      .WIDTH_ADDR_INST(6),
      .DEPTH_INST_MEM(64),
      .WIDTH_PARAM_MEM(128),
      .WIDTH_ADDR_PARAM(13),
      .DEPTH_PARAM_MEM(7000),
      .WIDTH_ACT_MEM(8),
      .WIDTH_ADDR_ACT(12),
      .DEPTH_ACT_MEM(4096),
      .INST_MEM_HEADER(2'b11),
      .PARAM_MEM_HEADER(2'b01),
      .ACT_MEM_HEADER(2'b10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .spi_clk(spi_clk),
      .MOSI(MOSI),
      .chip_select_n(chip_select_n),
      .inst_we(inst_we),
      .inst_addr(inst_addr),
      .inst_wdata(inst_wdata),
      .param_we(param_we),
      .param_addr(param_addr),
      .param_wdata(param_wdata),
      .act_we(act_we),
      .act_addr(act_addr),
      .act_wdata(act_wdata),
      .frame_active(frame_active),
      .frame_done(frame_done),
      .header_err(header_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Write record: {mem[1:0], addr[15:0], data[127:0]}; mem 0=inst 1=param 2=act.
   logic [145:0] wq[$];
   int           wcyc[$];
   int           fd_count = 0;
   int           fd_cyc = 0;
   logic         multi_we = 1'b0;

   // Write/frame_done monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (inst_we) begin
         wq.push_back({2'd0, 16'(inst_addr), 128'(inst_wdata)});
         wcyc.push_back(cyc);
      end
      if (param_we) begin
         wq.push_back({2'd1, 16'(param_addr), 128'(param_wdata)});
         wcyc.push_back(cyc);
      end
      if (act_we) begin
         wq.push_back({2'd2, 16'(act_addr), 128'(act_wdata)});
         wcyc.push_back(cyc);
      end
      if ((int'(inst_we) + int'(param_we) + int'(act_we)) > 1) multi_we = 1'b1;
      if (frame_done) begin
         fd_count++;
         fd_cyc = cyc;
      end
   end

   int checks = 0;
   int errors = 0;
   int half = 4;
   int last_rise_cyc = 0;
   int cs_rise_cyc = 0;
   logic [7:0] fb[$];

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [145:0] wr(input int mem, input int addr, input logic [127:0] data);
      return {2'(mem), 16'(addr), data};
   endfunction

   task automatic chk_wr(input string tag, input int idx, input logic [145:0] exp);
      logic [145:0] obs;
      obs = (idx < wq.size()) ? wq[idx] : '1;
      chk(tag, 160'(obs), 160'(exp));
   endtask

   task automatic clkw(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         MOSI = b[i];
         clkw(half);
         spi_clk = 1'b1;
         if (i == 0) last_rise_cyc = cyc;
         clkw(half);
         spi_clk = 1'b0;
      end
   endtask

   task automatic send_fb();
      foreach (fb[i]) send_byte(fb[i]);
   endtask

   task automatic frame_open();
      wq.delete();
      wcyc.delete();
      fd_count = 0;
      chip_select_n = 1'b0;
      clkw(6);
   endtask

   task automatic frame_close();
      clkw(6);
      chip_select_n = 1'b1;
      cs_rise_cyc = cyc;
      clkw(10);
   endtask

   initial begin
      reset = 1'b1;
      spi_clk = 1'b0;
      MOSI = 1'b0;
      chip_select_n = 1'b1;
      clkw(5);
      reset = 1'b0;
      clkw(4);

      // Reset state
      chk("rst_we", 160'({inst_we, param_we, act_we}), 160'd0);
      chk("rst_addr", 160'({inst_addr, param_addr, act_addr}), 160'd0);
      chk("rst_wdata", 160'({inst_wdata, param_wdata, act_wdata}), 160'd0);
      chk("rst_flags", 160'({frame_active, frame_done, header_err}), 160'd0);

      // Activation load
      frame_open();
      fb = {8'h80, 8'h00, 8'h05, 8'hA1, 8'hB2};
      send_fb();
      clkw(2);
      chk("act_active", 160'(frame_active), 160'd1);
      frame_close();
      chk("act_nwr", 160'(wq.size()), 160'd2);
      chk_wr("act_wr0", 0, wr(2, 5, 128'hA1));
      chk_wr("act_wr1", 1, wr(2, 6, 128'hB2));
      chk("act_done", 160'(fd_count), 160'd1);
      chk("act_idle", 160'(frame_active), 160'd0);
      chk("act_hold", 160'({act_addr, act_wdata}), 160'({12'd6, 8'hB2}));
      chk("fd_lat_ok", 160'((fd_cyc - cs_rise_cyc) >= 2 && (fd_cyc - cs_rise_cyc) <= 4), 160'd1);

      // Instruction load with wrap at 64
      frame_open();
      fb = {8'hC0, 8'h00, 8'h3F};
      for (int i = 1; i <= 20; i++) fb.push_back(8'(i));
      send_fb();
      frame_close();
      chk("inst_nwr", 160'(wq.size()), 160'd2);
      chk_wr("inst_wr0", 0, wr(0, 63, 128'h0102030405060708090A));
      chk_wr("inst_wr1", 1, wr(0, 0, 128'h0B0C0D0E0F1011121314));

      // Parameter load at 6999, then a partial word that must be dropped
      frame_open();
      fb = {8'h40, 8'h1B, 8'h57};
      for (int i = 0; i < 23; i++) fb.push_back(8'(8'h20 + i));
      send_fb();
      frame_close();
      chk("par_nwr", 160'(wq.size()), 160'd1);
      chk_wr("par_wr0", 0, wr(1, 6999, 128'h202122232425262728292A2B2C2D2E2F));
      chk("par_done", 160'(fd_count), 160'd1);

      // Next parameter frame must start with an empty packer
      frame_open();
      fb = {8'h40, 8'h00, 8'h02};
      for (int i = 0; i < 16; i++) fb.push_back(8'(8'h30 + i));
      send_fb();
      frame_close();
      chk("par2_nwr", 160'(wq.size()), 160'd1);
      chk_wr("par2_wr0", 0, wr(1, 2, 128'h303132333435363738393A3B3C3D3E3F));

      // Invalid header
      frame_open();
      fb = {8'h00, 8'hC0, 8'h00, 8'h01, 8'h11};
      send_fb();
      frame_close();
      chk("bad_nwr", 160'(wq.size()), 160'd0);
      chk("bad_err", 160'(header_err), 160'd1);
      chk("bad_done", 160'(fd_count), 160'd1);
      frame_open();
      fb = {8'h80, 8'h00, 8'h07, 8'h99};
      send_fb();
      frame_close();
      chk("bad_next_nwr", 160'(wq.size()), 160'd1);
      chk_wr("bad_next_wr", 0, wr(2, 7, 128'h99));
      chk("bad_sticky", 160'(header_err), 160'd1);

      // Reset mid-frame
      frame_open();
      fb = {8'h80, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33};
      send_fb();
      clkw(8);
      chk("rmf_pre_nwr", 160'(wq.size()), 160'd3);
      chk_wr("rmf_pre_wr2", 2, wr(2, 32'h22, 128'h33));
      reset = 1'b1;
      clkw(2);
      reset = 1'b0;
      chk("rmf_we", 160'({inst_we, param_we, act_we}), 160'd0);
      chk("rmf_addr", 160'({inst_addr, param_addr, act_addr}), 160'd0);
      chk("rmf_wdata", 160'({inst_wdata, param_wdata, act_wdata}), 160'd0);
      chk("rmf_flags", 160'({frame_active, frame_done, header_err}), 160'd0);
      wq.delete();
      fd_count = 0;
      fb = {8'h80, 8'h00, 8'h30, 8'h44};
      send_fb();
      clkw(8);
      chk("rmf_nowr", 160'(wq.size()), 160'd0);
      chk("rmf_inactive", 160'(frame_active), 160'd0);
      chip_select_n = 1'b1;
      clkw(10);
      chk("rmf_nodone", 160'(fd_count), 160'd0);
      frame_open();
      fb = {8'h80, 8'h00, 8'h31, 8'h66};
      send_fb();
      frame_close();
      chk("rmf_resume_nwr", 160'(wq.size()), 160'd1);
      chk_wr("rmf_resume_wr", 0, wr(2, 32'h31, 128'h66));

      // Timing margin: spi_clk phases of 3 clk periods
      half = 3;
      frame_open();
      fb = {8'h80, 8'h00, 8'h40, 8'hC3, 8'h5A};
      send_fb();
      clkw(8);
      chk("tm_nwr", 160'(wq.size()), 160'd2);
      chk_wr("tm_wr0", 0, wr(2, 32'h40, 128'hC3));
      chk_wr("tm_wr1", 1, wr(2, 32'h41, 128'h5A));
      chk("tm_lat_ok", 160'(wcyc.size() == 2 && (wcyc[1] - last_rise_cyc) >= 3 && (wcyc[1] - last_rise_cyc) <= 5), 160'd1);
      frame_close();
      chk("tm_done", 160'(fd_count), 160'd1);

      chk("one_we", 160'(multi_we), 160'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
